// File: rtl/fmap_pkg.sv
// Shared types and width helpers for the feature-map buffer arbiter.
// Round-robin arbitration is selected with `define FMAP_ARB_RR_EN.
package fmap_pkg;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 5408;

    // Address width; kept at least 1 so a single-word frame still has a port.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Counter width able to hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fmap_buf_arbiter_if.sv
// Producer, consumer and RAM port bundle for fmap_buf_arbiter.
// slave = arbiter side, master = environment (engines + RAM) side.
interface fmap_buf_arbiter_if
    import fmap_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = addr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic             wr_clear;
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             frame_done;
    logic [CW-1:0]    wr_count;

    logic             rd_req;
    logic [AW-1:0]    rd_addr;
    logic             rd_gnt;
    logic             rd_rvalid;
    logic [WIDTH-1:0] rd_rdata;

    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_din;
    logic [WIDTH-1:0] ram_dout;

    modport slave (
        input  wr_clear, wr_valid, wr_data, rd_req, rd_addr, ram_dout,
        output wr_ready, frame_done, wr_count, rd_gnt, rd_rvalid, rd_rdata,
        output ram_we, ram_addr, ram_din
    );

    modport master (
        output wr_clear, wr_valid, wr_data, rd_req, rd_addr, ram_dout,
        input  wr_ready, frame_done, wr_count, rd_gnt, rd_rvalid, rd_rdata,
        input  ram_we, ram_addr, ram_din
    );

endinterface

// File: rtl/fmap_rr_pick.sv
// Two-requester pick (producer write vs consumer read), one winner per cycle.
// FMAP_ARB_RR_EN: alternate on conflict via last_win; otherwise read has fixed priority.
module fmap_rr_pick
    import fmap_pkg::*;
(
`ifdef FMAP_ARB_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic wr_elig,
    input  logic rd_elig,
    output gnt_t gnt
);

`ifdef FMAP_ARB_RR_EN
    gnt_t last_win;

    // Only contended grants move the pointer; uncontended ones leave it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_win <= GNT_RD;
        else if (wr_elig && rd_elig)
            last_win <= gnt;
    end

    always_comb begin
        gnt = GNT_NONE;
        if (wr_elig && rd_elig)
            gnt = (last_win == GNT_RD) ? GNT_WR : GNT_RD;
        else if (wr_elig)
            gnt = GNT_WR;
        else if (rd_elig)
            gnt = GNT_RD;
    end
`else
    // Read always wins: bounded consumer latency, producer may starve.
    always_comb begin
        gnt = GNT_NONE;
        if (rd_elig)
            gnt = GNT_RD;
        else if (wr_elig)
            gnt = GNT_WR;
    end
`endif

endmodule

// File: rtl/fmap_buf_arbiter.sv
// Single-port feature-map RAM controller: streaming writer vs random reader, frame fill tracking.
// Arbitration policy selected by `define FMAP_ARB_RR_EN (round robin) else read-priority.
module fmap_buf_arbiter
    import fmap_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
)(
    input  logic               clk,
    input  logic               rst,
    fmap_buf_arbiter_if.slave  bus
);
    localparam int AW = addr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    state_t        state, state_nxt;
    gnt_t          gnt;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] wr_count;
    logic [AW-1:0] addr_hold;
    logic          wr_elig;
    logic          wr_acc;
    logic          last_word;

    assign wr_elig   = bus.wr_valid && (state != FULL) && !bus.wr_clear;
    assign wr_acc    = (gnt == GNT_WR);
    assign last_word = (wr_count == CW'(DEPTH - 1));

    fmap_rr_pick u_pick (
`ifdef FMAP_ARB_RR_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .wr_elig (wr_elig),
        .rd_elig (bus.rd_req),
        .gnt     (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.ram_we   = 1'b0;
        bus.ram_addr = addr_hold;
        bus.wr_ready = 1'b0;
        bus.rd_gnt   = 1'b0;

        unique case (gnt)
            GNT_WR: begin
                bus.ram_we   = 1'b1;
                bus.ram_addr = wr_ptr;
                bus.wr_ready = 1'b1;
            end
            GNT_RD: begin
                bus.ram_addr = bus.rd_addr;
                bus.rd_gnt   = 1'b1;
            end
            default: ;
        endcase

        if (bus.wr_clear)
            state_nxt = EMPTY;
        else if (wr_acc)
            state_nxt = last_word ? FULL : FILLING;
    end

    // wr_ptr saturates at DEPTH-1; the FULL state blocks further writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            wr_count <= '0;
        end else if (bus.wr_clear) begin
            wr_ptr   <= '0;
            wr_count <= '0;
        end else if (wr_acc) begin
            wr_count <= wr_count + CW'(1);
            if (wr_ptr != AW'(DEPTH - 1))
                wr_ptr <= wr_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hold      <= '0;
            bus.rd_rvalid  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            addr_hold      <= bus.ram_addr;
            bus.rd_rvalid  <= bus.rd_gnt;
            bus.frame_done <= wr_acc && last_word;
        end
    end

    assign bus.wr_count = wr_count;
    assign bus.ram_din  = bus.wr_data;
    assign bus.rd_rdata = bus.ram_dout;

endmodule
